// File: rtl/mem_pkg.sv
// Shared types and widths for the external memory port and its arbiter.
package mem_pkg;

    localparam int unsigned MEM_ADDR_W = 20;
    localparam int unsigned MEM_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MEM  = 2'b01,
        RESP = 2'b10
    } arb_state_t;

    typedef enum logic {
        OWN_IC = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

endpackage

// File: rtl/imem_arbiter_if.sv
// Bundle of icache, data-side and memory-controller signals around imem_arbiter.
// slave = the arbiter itself; master = its surroundings (requesters and memory).
interface imem_arbiter_if #(
    parameter int unsigned ADDR_W = mem_pkg::MEM_ADDR_W,
    parameter int unsigned DATA_W = mem_pkg::MEM_DATA_W
);
    logic              ic_req;
    logic [ADDR_W-1:0] ic_addr;
    logic              ic_fetch;
    logic [DATA_W-1:0] ic_data;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [3:0]        d_wmask;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_wmask;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;
    logic              timeout;

    modport slave (
        input  ic_req, ic_addr, d_req, d_we, d_addr, d_wdata, d_wmask, mem_ready, mem_rdata,
        output ic_fetch, ic_data, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_wdata,
               mem_wmask, busy, timeout
    );

    modport master (
        output ic_req, ic_addr, d_req, d_we, d_addr, d_wdata, d_wmask, mem_ready, mem_rdata,
        input  ic_fetch, ic_data, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_wdata,
               mem_wmask, busy, timeout
    );

endinterface

// File: rtl/arb_pick.sv
// Combinational tie-breaker between icache and data requests.
// IMEM_ARB_RR_EN selects round-robin; otherwise the data side always wins ties.
module arb_pick
    import mem_pkg::*;
(
`ifdef IMEM_ARB_RR_EN
    input  owner_t last_grant,
`endif
    input  logic   ic_req,
    input  logic   d_req,
    output owner_t grant
);

    always_comb begin
        grant = OWN_D;
        if (ic_req && d_req) begin
`ifdef IMEM_ARB_RR_EN
            grant = (last_grant == OWN_D) ? OWN_IC : OWN_D;
`else
            grant = OWN_D;
`endif
        end else if (ic_req) begin
            grant = OWN_IC;
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// Sequencer for the shared external memory port: IDLE -> MEM -> RESP with a watchdog.
// Define IMEM_ARB_RR_EN for round-robin tie-breaking (fixed data priority otherwise).
module imem_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_W   = MEM_ADDR_W,
    parameter int unsigned DATA_W   = MEM_DATA_W,
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    imem_arbiter_if.slave         bus
);

    // Counter value in the last MEM cycle allowed before the watchdog fires.
    localparam logic [7:0] WdLast = 8'(MAX_WAIT - 1);

    arb_state_t        state_q, state_d;
    owner_t            owner_q, owner_d;
    owner_t            grant;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_wmask_q, mem_wmask_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic              ic_fetch_q, ic_fetch_d;
    logic              d_ack_q, d_ack_d;
    logic              timeout_q, timeout_d;
    logic [7:0]        wd_cnt_q, wd_cnt_d;

    // owner_q doubles as the last-grant record for round-robin.
    arb_pick u_arb_pick (
`ifdef IMEM_ARB_RR_EN
        .last_grant (owner_q),
`endif
        .ic_req     (bus.ic_req),
        .d_req      (bus.d_req),
        .grant      (grant)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wmask_d = mem_wmask_q;
        resp_data_d = resp_data_q;
        wd_cnt_d    = wd_cnt_q;
        ic_fetch_d  = 1'b0;
        d_ack_d     = 1'b0;
        timeout_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.ic_req || bus.d_req) begin
                    state_d   = MEM;
                    owner_d   = grant;
                    mem_req_d = 1'b1;
                    wd_cnt_d  = 8'd0;
                    if (grant == OWN_IC) begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = bus.ic_addr;
                        mem_wdata_d = '0;
                        mem_wmask_d = 4'hF;
                    end else begin
                        mem_we_d    = bus.d_we;
                        mem_addr_d  = bus.d_addr;
                        mem_wdata_d = bus.d_wdata;
                        mem_wmask_d = bus.d_wmask;
                    end
                end
            end
            MEM: begin
                if (bus.mem_ready) begin
                    state_d     = RESP;
                    mem_req_d   = 1'b0;
                    resp_data_d = bus.mem_rdata;
                    ic_fetch_d  = (owner_q == OWN_IC);
                    d_ack_d     = (owner_q == OWN_D);
                end else if (wd_cnt_q == WdLast) begin
                    state_d     = RESP;
                    mem_req_d   = 1'b0;
                    resp_data_d = '0;
                    timeout_d   = 1'b1;
                    ic_fetch_d  = (owner_q == OWN_IC);
                    d_ack_d     = (owner_q == OWN_D);
                end else begin
                    wd_cnt_d = wd_cnt_q + 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            owner_q     <= OWN_D;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wmask_q <= 4'h0;
            resp_data_q <= '0;
            ic_fetch_q  <= 1'b0;
            d_ack_q     <= 1'b0;
            timeout_q   <= 1'b0;
            wd_cnt_q    <= 8'd0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wmask_q <= mem_wmask_d;
            resp_data_q <= resp_data_d;
            ic_fetch_q  <= ic_fetch_d;
            d_ack_q     <= d_ack_d;
            timeout_q   <= timeout_d;
            wd_cnt_q    <= wd_cnt_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_wmask = mem_wmask_q;
    assign bus.ic_fetch  = ic_fetch_q;
    assign bus.ic_data   = resp_data_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.d_rdata   = resp_data_q;
    assign bus.timeout   = timeout_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter (MAX_WAIT=4); tie expectations follow IMEM_ARB_RR_EN.
module tb_imem_arbiter;
    import mem_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    owner_t tie_exp [3];

    imem_arbiter_if bus ();

    imem_arbiter #(
        .ADDR_W   (20),
        .DATA_W   (32),
        .MAX_WAIT (4)
    ) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit observed=running expected=finished");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        bus.ic_req    = 1'b0;
        bus.ic_addr   = '0;
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.d_wmask   = 4'h0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
`ifdef IMEM_ARB_RR_EN
        tie_exp[0] = OWN_IC; tie_exp[1] = OWN_D; tie_exp[2] = OWN_IC;
`else
        tie_exp[0] = OWN_D;  tie_exp[1] = OWN_D; tie_exp[2] = OWN_D;
`endif

        // Reset values
        #3;
        check("rst_busy",      32'(bus.busy),      32'h0);
        check("rst_mem_req",   32'(bus.mem_req),   32'h0);
        check("rst_mem_we",    32'(bus.mem_we),    32'h0);
        check("rst_ic_fetch",  32'(bus.ic_fetch),  32'h0);
        check("rst_d_ack",     32'(bus.d_ack),     32'h0);
        check("rst_timeout",   32'(bus.timeout),   32'h0);
        check("rst_mem_addr",  32'(bus.mem_addr),  32'h0);
        check("rst_mem_wdata", bus.mem_wdata,      32'h0);
        check("rst_mem_wmask", 32'(bus.mem_wmask), 32'h0);
        check("rst_ic_data",   bus.ic_data,        32'h0);
        check("rst_d_rdata",   bus.d_rdata,        32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Icache refill, memory answers in the second MEM cycle
        bus.ic_req  = 1'b1;
        bus.ic_addr = 20'h00404;
        tick();
        check("ic_mem_req",   32'(bus.mem_req),   32'h1);
        check("ic_mem_addr",  32'(bus.mem_addr),  32'h00404);
        check("ic_mem_we",    32'(bus.mem_we),    32'h0);
        check("ic_mem_wmask", 32'(bus.mem_wmask), 32'hF);
        check("ic_busy",      32'(bus.busy),      32'h1);
        tick();
        check("ic_wait_req",   32'(bus.mem_req),  32'h1);
        check("ic_wait_fetch", 32'(bus.ic_fetch), 32'h0);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h00B70113;
        tick();
        check("ic_fetch",     32'(bus.ic_fetch), 32'h1);
        check("ic_data",      bus.ic_data,       32'h00B70113);
        check("ic_no_d_ack",  32'(bus.d_ack),    32'h0);
        check("ic_req_drop",  32'(bus.mem_req),  32'h0);
        check("ic_no_tmo",    32'(bus.timeout),  32'h0);
        bus.mem_ready = 1'b0;
        bus.ic_req    = 1'b0;
        tick();
        check("ic_fetch_end", 32'(bus.ic_fetch), 32'h0);
        check("ic_idle",      32'(bus.busy),     32'h0);

        // Store with mem_ready held high: minimum 3-cycle occupancy
        bus.d_req     = 1'b1;
        bus.d_we      = 1'b1;
        bus.d_addr    = 20'h00010;
        bus.d_wdata   = 32'hDEADBEEF;
        bus.d_wmask   = 4'h3;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h12345678;
        tick();
        check("st_mem_req",   32'(bus.mem_req),   32'h1);
        check("st_mem_we",    32'(bus.mem_we),    32'h1);
        check("st_mem_addr",  32'(bus.mem_addr),  32'h00010);
        check("st_mem_wdata", bus.mem_wdata,      32'hDEADBEEF);
        check("st_mem_wmask", 32'(bus.mem_wmask), 32'h3);
        check("st_no_ack",    32'(bus.d_ack),     32'h0);
        tick();
        check("st_d_ack",     32'(bus.d_ack),     32'h1);
        check("st_no_fetch",  32'(bus.ic_fetch),  32'h0);
        check("st_d_rdata",   bus.d_rdata,        32'h12345678);
        check("st_req_drop",  32'(bus.mem_req),   32'h0);
        bus.d_req     = 1'b0;
        bus.mem_ready = 1'b0;
        tick();
        check("st_ack_end",   32'(bus.d_ack),     32'h0);
        check("st_idle",      32'(bus.busy),      32'h0);

        // Tie with both requests held across three transactions
        bus.ic_req    = 1'b1;
        bus.ic_addr   = 20'h00800;
        bus.d_req     = 1'b1;
        bus.d_we      = 1'b0;
        bus.d_addr    = 20'h00020;
        bus.d_wmask   = 4'hF;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hA5A50001;
        for (int t = 0; t < 3; t++) begin
            tick();
            check("tie_addr", 32'(bus.mem_addr),
                  (tie_exp[t] == OWN_IC) ? 32'h00800 : 32'h00020);
            tick();
            check("tie_fetch", 32'(bus.ic_fetch), (tie_exp[t] == OWN_IC) ? 32'h1 : 32'h0);
            check("tie_ack",   32'(bus.d_ack),    (tie_exp[t] == OWN_D)  ? 32'h1 : 32'h0);
            tick();
            check("tie_idle",  32'(bus.busy),     32'h0);
        end
        bus.d_req = 1'b0;
        tick();
        check("tie_ic_addr", 32'(bus.mem_addr), 32'h00800);
        tick();
        check("tie_ic_fetch", 32'(bus.ic_fetch), 32'h1);
        check("tie_ic_noack", 32'(bus.d_ack),    32'h0);
        bus.ic_req    = 1'b0;
        bus.mem_ready = 1'b0;
        tick();

        // Watchdog: memory never answers
        bus.ic_req  = 1'b1;
        bus.ic_addr = 20'h00ABC;
        tick();
        for (int i = 0; i < 4; i++) begin
            check("tmo_mem_req", 32'(bus.mem_req), 32'h1);
            check("tmo_pending", 32'(bus.timeout), 32'h0);
            tick();
        end
        check("tmo_req_drop", 32'(bus.mem_req),  32'h0);
        check("tmo_pulse",    32'(bus.timeout),  32'h1);
        check("tmo_fetch",    32'(bus.ic_fetch), 32'h1);
        check("tmo_data",     bus.ic_data,       32'h0);
        bus.ic_req = 1'b0;
        tick();
        check("tmo_pulse_end", 32'(bus.timeout), 32'h0);
        check("tmo_idle",      32'(bus.busy),    32'h0);

        // mem_ready in the last allowed cycle beats the watchdog
        bus.ic_req = 1'b1;
        tick();
        tick();
        tick();
        tick();
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hCAFE0004;
        tick();
        check("race_no_tmo", 32'(bus.timeout),  32'h0);
        check("race_fetch",  32'(bus.ic_fetch), 32'h1);
        check("race_data",   bus.ic_data,       32'hCAFE0004);
        bus.ic_req    = 1'b0;
        bus.mem_ready = 1'b0;
        tick();

        // Reset during MEM, icache request held throughout
        bus.ic_req  = 1'b1;
        bus.ic_addr = 20'h00555;
        tick();
        check("rmid_mem_req", 32'(bus.mem_req), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("rmid_req_async", 32'(bus.mem_req),  32'h0);
        check("rmid_busy",      32'(bus.busy),     32'h0);
        check("rmid_addr",      32'(bus.mem_addr), 32'h0);
        check("rmid_ic_data",   bus.ic_data,       32'h0);
        check("rmid_wmask",     32'(bus.mem_wmask), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        check("rmid_restart_req",  32'(bus.mem_req),  32'h1);
        check("rmid_restart_addr", 32'(bus.mem_addr), 32'h00555);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h0BADF00D;
        tick();
        check("rmid_fetch", 32'(bus.ic_fetch), 32'h1);
        check("rmid_data",  bus.ic_data,       32'h0BADF00D);
        bus.ic_req    = 1'b0;
        bus.mem_ready = 1'b0;
        tick();
        check("rmid_idle", 32'(bus.busy), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
